// File: rtl/wdb_agent.sv
// wdb_agent: write-data buffer between the upstream line writer and the data SRAM.
// Entries cycle FREE -> FILLED -> DRAINING -> FREE. Each entry is released
// WR_SRAM_DELAY cycles after its data is launched to the SRAM.
// Optional macro WDB_CHECK_EN compiles in simulation-only protocol/consistency checks.
module wdb_agent #(
    parameter int ENTRY_NUM      = 16,
    parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
    parameter int DATA_WIDTH     = 1024,
    parameter int WR_SRAM_DELAY  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      us_wr_vld,
    input  logic [DATA_WIDTH-1:0]     us_wr_data,
    output logic                      us_wr_rdy,
    output logic                      alloc_vld,
    output logic [ENTRY_ID_WIDTH-1:0] alloc_idx,
    input  logic                      dataram_wr_vld,
    input  logic [ENTRY_ID_WIDTH-1:0] dataram_wr_idx,
    output logic                      dataram_wr_rdy,
    output logic                      wdb_to_ram_data_vld,
    output logic [DATA_WIDTH-1:0]     wdb_to_ram_data,
    output logic                      wr_done,
    output logic [ENTRY_ID_WIDTH-1:0] wr_done_idx,
    output logic [ENTRY_ID_WIDTH:0]   occupancy
);

    typedef enum logic [1:0] {
        ENT_FREE     = 2'd0,
        ENT_FILLED   = 2'd1,
        ENT_DRAINING = 2'd2
    } ent_state_e;

    ent_state_e                r_state     [ENTRY_NUM];
    ent_state_e                w_state_nxt [ENTRY_NUM];
    logic [DATA_WIDTH-1:0]     r_mem       [ENTRY_NUM];
    logic [ENTRY_ID_WIDTH:0]   r_occ;
    logic                      r_ram_vld;
    logic [ENTRY_ID_WIDTH-1:0] r_ram_idx;
    logic [DATA_WIDTH-1:0]     r_ram_data;
    logic                      r_pipe_vld  [WR_SRAM_DELAY];
    logic [ENTRY_ID_WIDTH-1:0] r_pipe_idx  [WR_SRAM_DELAY];

    logic                      w_any_free;
    logic [ENTRY_ID_WIDTH-1:0] w_free_idx;
    logic                      w_alloc;
    logic                      w_drain;

    // Lowest-index FREE entry (scan downward so the lowest match wins).
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int unsigned i = ENTRY_NUM; i > 0; i--) begin
            if (r_state[i-1] == ENT_FREE) begin
                w_any_free = 1'b1;
                w_free_idx = ENTRY_ID_WIDTH'(i - 1);
            end
        end
    end

    assign us_wr_rdy           = w_any_free;
    assign w_alloc             = us_wr_vld && w_any_free;
    assign alloc_vld           = w_alloc;
    assign alloc_idx           = w_free_idx;
    assign w_drain             = dataram_wr_vld && (r_state[dataram_wr_idx] == ENT_FILLED);
    assign dataram_wr_rdy      = w_drain;
    assign wdb_to_ram_data_vld = r_ram_vld;
    assign wdb_to_ram_data     = r_ram_data;
    assign wr_done             = r_pipe_vld[WR_SRAM_DELAY-1];
    assign wr_done_idx         = r_pipe_idx[WR_SRAM_DELAY-1];
    assign occupancy           = r_occ;

    // Per-entry next state; alloc, drain and release always target distinct entries.
    always_comb begin
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            w_state_nxt[i] = r_state[i];
        end
        if (w_alloc) begin
            w_state_nxt[w_free_idx] = ENT_FILLED;
        end
        if (w_drain) begin
            w_state_nxt[dataram_wr_idx] = ENT_DRAINING;
        end
        if (wr_done) begin
            w_state_nxt[wr_done_idx] = ENT_FREE;
        end
    end

    // Entry state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                r_state[i] <= ENT_FREE;
            end
        end else begin
            for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    // Line storage, written on the allocation handshake; no reset needed.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_mem[w_free_idx] <= us_wr_data;
        end
    end

    // Data launch to the SRAM one cycle after the drain handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_vld  <= 1'b0;
            r_ram_idx  <= '0;
            r_ram_data <= '0;
        end else begin
            r_ram_vld <= w_drain;
            if (w_drain) begin
                r_ram_idx  <= dataram_wr_idx;
                r_ram_data <= r_mem[dataram_wr_idx];
            end
        end
    end

    // Write-complete delay line of {vld, idx}; reset drops in-flight drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WR_SRAM_DELAY; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_idx[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= r_ram_vld;
            r_pipe_idx[0] <= r_ram_idx;
            for (int unsigned i = 1; i < WR_SRAM_DELAY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end
        end
    end

    // Occupancy counter: +1 on alloc, -1 on release, net 0 when both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else begin
            case ({w_alloc, wr_done})
                2'b10:   r_occ <= r_occ + (ENTRY_ID_WIDTH+1)'(1);
                2'b01:   r_occ <= r_occ - (ENTRY_ID_WIDTH+1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef WDB_CHECK_EN
    logic                  r_chk_hold;
    logic [DATA_WIDTH-1:0] r_chk_data;

    // Remember a stalled upstream request so the next cycle can verify it was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_hold <= 1'b0;
            r_chk_data <= '0;
        end else begin
            r_chk_hold <= us_wr_vld && !us_wr_rdy;
            r_chk_data <= us_wr_data;
        end
    end

    // Simulation-only protocol and bookkeeping checks.
    always @(posedge clk) begin
        if (rst_n) begin
            int unsigned busy_cnt;
            busy_cnt = 0;
            for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                if (r_state[i] != ENT_FREE) busy_cnt++;
            end
            if (dataram_wr_vld && (r_state[dataram_wr_idx] == ENT_FREE))
                $error("wdb_agent: drain request to FREE entry %0d", dataram_wr_idx);
            if (wr_done && (r_state[wr_done_idx] != ENT_DRAINING))
                $error("wdb_agent: wr_done on non-draining entry %0d", wr_done_idx);
            if (busy_cnt != 32'(r_occ))
                $error("wdb_agent: occupancy %0d vs busy entries %0d", r_occ, busy_cnt);
            if (r_chk_hold && (!us_wr_vld || (us_wr_data != r_chk_data)))
                $error("wdb_agent: upstream request changed while stalled");
        end
    end
`else
    // Checks not compiled in.
`endif

endmodule
